// File: rtl/led_seq_ctrl.sv
// LED sequencer: register-programmed chase / bounce / blink / manual-step patterns
// driven by a PERIOD-based prescaler, with a one-cycle step_tick on every advance.
module led_seq_ctrl #(
  parameter int NUM_LED = 7,
  parameter int PRESC_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [PRESC_W-1:0] cfg_wdata,
  output logic [PRESC_W-1:0] cfg_rdata,
  output logic [NUM_LED-1:0] led,
  output logic               step_tick
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  typedef enum logic [1:0] {CHASE = 2'b00, BOUNCE = 2'b01, BLINK = 2'b10, MANUAL = 2'b11} mode_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_STEP   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;
  localparam logic [3:0] LAST_POS    = 4'(NUM_LED - 1);

  state_t             state, state_n;
  mode_t              mode, mode_n;
  logic               dir, dir_n;
  logic               bdir, bdir_n;
  logic [PRESC_W-1:0] period, period_n;
  logic [PRESC_W-1:0] count, count_n;
  logic [3:0]         pos, pos_n;
  logic [NUM_LED-1:0] led_n;
  logic               tick_n;

  logic ctrl_wr, period_wr, step_wr, terminal;

  function automatic logic [NUM_LED-1:0] one_hot(input logic [3:0] p);
    return NUM_LED'(1) << p;
  endfunction

  function automatic logic [3:0] chase_step(input logic [3:0] p, input logic down);
    if (down) return (p == 4'd0) ? LAST_POS : p - 4'd1;
    return (p == LAST_POS) ? 4'd0 : p + 4'd1;
  endfunction

  assign ctrl_wr   = cfg_we && (cfg_addr == ADDR_CTRL);
  assign period_wr = cfg_we && (cfg_addr == ADDR_PERIOD);
  assign step_wr   = cfg_we && (cfg_addr == ADDR_STEP);
  assign terminal  = (count == period);

  always_comb begin
    // NOTE: every next-value signal is defaulted first so no path can infer a latch.
    state_n  = state;
    mode_n   = mode;
    dir_n    = dir;
    bdir_n   = bdir;
    period_n = period;
    count_n  = count;
    pos_n    = pos;
    led_n    = led;
    tick_n   = 1'b0;

    if (period_wr) period_n = cfg_wdata;

    if (ctrl_wr) begin
      // A CTRL write re-arms the sequence and swallows any coincident terminal count.
      state_n = cfg_wdata[0] ? RUN : IDLE;
      mode_n  = mode_t'(cfg_wdata[2:1]);
      dir_n   = cfg_wdata[3];
      bdir_n  = cfg_wdata[3];
      count_n = '0;
      led_n   = (cfg_wdata[0] && (mode_t'(cfg_wdata[2:1]) != BLINK)) ? one_hot(pos) : '0;
    end else if (state == IDLE) begin
      count_n = '0;
      led_n   = '0;
    end else if (mode == MANUAL) begin
      count_n = '0;
      if (step_wr) begin
        pos_n  = chase_step(pos, dir);
        led_n  = one_hot(chase_step(pos, dir));
        tick_n = 1'b1;
      end
    end else if (period_wr && (count >= cfg_wdata)) begin
      count_n = '0;
    end else if (terminal) begin
      count_n = '0;
      tick_n  = 1'b1;
      case (mode)
        CHASE: begin
          pos_n = chase_step(pos, dir);
          led_n = one_hot(chase_step(pos, dir));
        end
        BOUNCE: begin
          if (!bdir) begin
            if (pos == LAST_POS) begin
              pos_n  = pos - 4'd1;
              bdir_n = 1'b1;
            end else begin
              pos_n = pos + 4'd1;
            end
          end else begin
            if (pos == 4'd0) begin
              pos_n  = 4'd1;
              bdir_n = 1'b0;
            end else begin
              pos_n = pos - 4'd1;
            end
          end
          led_n = one_hot(pos_n);
        end
        BLINK:   led_n = ~led;
        default: ;
      endcase
    end else begin
      count_n = count + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state     <= IDLE;
      mode      <= CHASE;
      dir       <= 1'b0;
      bdir      <= 1'b0;
      period    <= '1;
      count     <= '0;
      pos       <= '0;
      led       <= '0;
      step_tick <= 1'b0;
    end else begin
      state     <= state_n;
      mode      <= mode_n;
      dir       <= dir_n;
      bdir      <= bdir_n;
      period    <= period_n;
      count     <= count_n;
      pos       <= pos_n;
      led       <= led_n;
      step_tick <= tick_n;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_CTRL:   cfg_rdata[3:0] = {dir, mode, state == RUN};
      ADDR_PERIOD: cfg_rdata = period;
      ADDR_STATUS: begin
        cfg_rdata[7:4] = pos;
        cfg_rdata[1]   = bdir;
        cfg_rdata[0]   = (state == RUN);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: behavioural model compared every cycle, directed scenarios
// with literal expectations, then randomized register traffic.
module tb_led_seq_ctrl;
  localparam int N = 7;
  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst, cfg_we;
  logic [1:0]   cfg_addr;
  logic [W-1:0] cfg_wdata, cfg_rdata;
  logic [N-1:0] led;
  logic         step_tick;

  led_seq_ctrl #(.NUM_LED(N), .PRESC_W(W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .led(led), .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state: plain integers describing what the block should present.
  bit m_en, m_tick;
  int m_mode, m_dir, m_bdir, m_period, m_count, m_pos, m_led;
  localparam int ALL_LED = (1 << N) - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit we, input int a, input int d);
    int np;
    np = (we && a == 1) ? d : m_period;
    m_tick = 1'b0;
    if (r) begin
      m_en = 0; m_mode = 0; m_dir = 0; m_bdir = 0;
      m_period = ALL_LED == 0 ? 0 : (1 << W) - 1;
      m_count = 0; m_pos = 0; m_led = 0;
      return;
    end
    if (we && a == 0) begin
      m_en   = d[0];
      m_mode = (d >> 1) & 3;
      m_dir  = (d >> 3) & 1;
      m_bdir = m_dir;
      m_count = 0;
      m_led  = (m_en && m_mode != 2) ? (1 << m_pos) : 0;
    end else if (!m_en) begin
      m_count = 0;
      m_led   = 0;
    end else if (m_mode == 3) begin
      m_count = 0;
      if (we && a == 2) begin
        m_pos  = m_dir ? (m_pos + N - 1) % N : (m_pos + 1) % N;
        m_led  = 1 << m_pos;
        m_tick = 1'b1;
      end
    end else if (we && a == 1 && m_count >= np) begin
      m_count = 0;
    end else if (m_count == m_period) begin
      m_count = 0;
      m_tick  = 1'b1;
      if (m_mode == 0) begin
        m_pos = m_dir ? (m_pos + N - 1) % N : (m_pos + 1) % N;
        m_led = 1 << m_pos;
      end else if (m_mode == 1) begin
        if (m_bdir == 0 && m_pos == N - 1) begin m_pos = N - 2; m_bdir = 1; end
        else if (m_bdir == 1 && m_pos == 0) begin m_pos = 1; m_bdir = 0; end
        else m_pos = m_bdir ? m_pos - 1 : m_pos + 1;
        m_led = 1 << m_pos;
      end else begin
        m_led = (m_led == 0) ? ALL_LED : 0;
      end
    end else begin
      m_count++;
    end
    m_period = np;
  endtask

  function automatic int exp_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return (m_dir << 3) | (m_mode << 1) | int'(m_en);
      2'd1:    return m_period;
      2'd2:    return 0;
      default: return (m_pos << 4) | (m_bdir << 1) | int'(m_en);
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("led", 32'(led), m_led);
      check("step_tick", 32'(step_tick), 32'(m_tick));
      check("cfg_rdata", 32'(cfg_rdata), exp_rdata(cfg_addr));
    end
  end

  task automatic apply(input bit r, input bit we, input logic [1:0] a, input logic [W-1:0] d);
    rst = r; cfg_we = we; cfg_addr = a; cfg_wdata = d;
    @(posedge clk);
    model_step(r, we, int'(a), int'(d));
    #1;
  endtask

  task automatic idle(input int n, input logic [1:0] a = 2'd0);
    repeat (n) apply(1'b0, 1'b0, a, '0);
  endtask

  task automatic wait_tick(input int max, output int n);
    n = 0;
    do begin
      apply(1'b0, 1'b0, cfg_addr, '0);
      n++;
    end while (step_tick !== 1'b1 && n < max);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n;
  int bpos[13]  = '{1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1, 0, 1};
  int bbdir[13] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
  int mpos[3]   = '{6, 5, 4};
  bit           r_r, r_we;
  logic [1:0]   r_a;
  logic [W-1:0] r_d;

  initial begin
    // Reset, and reset beating a simultaneous CTRL write.
    apply(1'b1, 1'b0, 2'd1, '0);
    chk_en = 1'b1;
    check("reset led", 32'(led), 32'h0);
    check("reset period", 32'(cfg_rdata), 32'hFF_FFFF);
    apply(1'b1, 1'b1, 2'd0, 24'h1);
    idle(1, 2'd3);
    check("rst priority run", 32'(cfg_rdata[0]), 32'h0);

    // CHASE, PERIOD=3: tick every 4 cycles, 7 ticks wrap back to 0.
    apply(1'b0, 1'b1, 2'd1, 24'd3);
    apply(1'b0, 1'b1, 2'd0, 24'h1);
    wait_tick(20, n);
    check("chase first spacing", n, 4);
    check("chase first led", 32'(led), 32'b0000010);
    for (int k = 2; k <= 7; k++) begin
      wait_tick(20, n);
      check("chase spacing", n, 4);
    end
    check("chase wrap led", 32'(led), 32'b0000001);

    // CTRL write on the terminal count swallows the tick.
    idle(3);
    apply(1'b0, 1'b1, 2'd0, 24'h1);
    check("collision no tick", 32'(step_tick), 32'h0);
    check("collision hold led", 32'(led), 32'b0000001);
    wait_tick(20, n);
    check("collision next tick", n, 4);

    // PERIOD shrink 100 -> 5 at count 50.
    apply(1'b0, 1'b1, 2'd1, 24'd100);
    apply(1'b0, 1'b1, 2'd0, 24'h1);
    idle(50);
    apply(1'b0, 1'b1, 2'd1, 24'd5);
    check("shrink no tick", 32'(step_tick), 32'h0);
    wait_tick(50, n);
    check("shrink next tick", n, 6);

    // BOUNCE, PERIOD=0.
    apply(1'b1, 1'b0, 2'd0, '0);
    apply(1'b0, 1'b1, 2'd1, 24'd0);
    apply(1'b0, 1'b1, 2'd0, 24'h3);
    for (int i = 0; i < 13; i++) begin
      idle(1, 2'd3);
      check("bounce led", 32'(led), 1 << bpos[i]);
      check("bounce status", 32'(cfg_rdata[7:0]), (bpos[i] << 4) | (bbdir[i] << 1) | 1);
    end

    // MANUAL, dir=1: STEP writes walk 6,5,4 and nothing happens between them.
    apply(1'b1, 1'b0, 2'd0, '0);
    apply(1'b0, 1'b1, 2'd0, 24'hF);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b1, 2'd2, '0);
      check("manual tick", 32'(step_tick), 32'h1);
      check("manual led", 32'(led), 1 << mpos[i]);
      idle(3, 2'd3);
      check("manual gap", 32'(step_tick), 32'h0);
    end

    // BLINK from position 4, PERIOD=1, then disable.
    apply(1'b0, 1'b1, 2'd1, 24'd1);
    apply(1'b0, 1'b1, 2'd0, 24'h5);
    check("blink entry led", 32'(led), 32'h0);
    idle(2);
    check("blink on", 32'(led), 32'h7F);
    idle(2);
    check("blink off", 32'(led), 32'h0);
    idle(2);
    check("blink on again", 32'(led), 32'h7F);
    apply(1'b0, 1'b1, 2'd0, 24'h0);
    check("disable led", 32'(led), 32'h0);
    idle(1, 2'd3);
    check("disable status", 32'(cfg_rdata[7:0]), 32'h40);

    // Reset in the middle of a tick-every-cycle run.
    apply(1'b0, 1'b1, 2'd1, 24'd0);
    apply(1'b0, 1'b1, 2'd0, 24'h1);
    idle(3);
    apply(1'b1, 1'b0, 2'd1, '0);
    check("midrst led", 32'(led), 32'h0);
    check("midrst tick", 32'(step_tick), 32'h0);
    check("midrst period", 32'(cfg_rdata), 32'hFF_FFFF);
    cfg_addr = 2'd3;
    #1;
    check("midrst status", 32'(cfg_rdata), 32'h0);
    cfg_addr = 2'd0;
    #1;
    check("midrst ctrl", 32'(cfg_rdata), 32'h0);

    // Randomized register traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      r_r  = ($urandom_range(0, 199) == 0);
      r_we = ($urandom_range(0, 3) == 0);
      r_a  = 2'($urandom_range(0, 3));
      r_d  = (r_a == 2'd1) ? W'($urandom_range(0, 6)) : W'($urandom);
      apply(r_r, r_we, r_a, r_d);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter NUM_LED, default 7: number of LED outputs, legal range 2..16.
REQ-002 Parameter PRESC_W, default 24: width of the prescaler counter and the PERIOD register.
REQ-003 Port clk  input  1: single system clock; all logic is clocked on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous and active-high.
REQ-005 Port cfg_we  input  1: register write strobe, one write per asserted cycle.
REQ-006 Port cfg_addr  input  2: register address (0 CTRL, 1 PERIOD, 2 STEP, 3 STATUS).
REQ-007 Port cfg_wdata  input  PRESC_W: write data, LSB-aligned.
REQ-008 Port cfg_rdata  output  PRESC_W: combinational read data for cfg_addr.
REQ-009 Port led  output  NUM_LED: registered LED drive.
REQ-010 Port step_tick  output  1: registered one-cycle pulse on every sequence advance.

Function
REQ-011 CTRL register bit fields SHALL be:
- [0] enable.
- [2:1] mode: 00 CHASE, 01 BOUNCE, 10 BLINK, 11 MANUAL.
- [3] dir: 0 up, 1 down.
- Other bits: read 0.
REQ-012 STATUS register (read-only) SHALL read {position[3:0] at [7:4], bounce_dir at [1], run at [0]}; STEP register reads 0; writes to STATUS are ignored.
REQ-013 Controller SHALL have two states: IDLE (enable=0) and RUN (enable=1).
- IDLE->RUN occurs on a CTRL write with bit0=1.
- RUN->IDLE occurs on a CTRL write with bit0=0.
REQ-014 In RUN with mode!=MANUAL, the prescaler SHALL count 0..PERIOD.
- In the cycle where count==PERIOD, step_tick is 1 and count returns to 0.
- PERIOD=0 therefore gives a tick every cycle.
REQ-015 On a tick, position and led SHALL update at the same clock edge that ends the tick cycle.
REQ-016 CHASE: position SHALL advance by +1 (dir=0) or -1 (dir=1), wrapping NUM_LED-1->0 and 0->NUM_LED-1.
REQ-017 BOUNCE: position SHALL move in bounce_dir and reverse at the ends.
- At NUM_LED-1 moving up: next is NUM_LED-2, bounce_dir flips to down.
- At 0 moving down: next is 1, bounce_dir flips to up.
REQ-018 CHASE, BOUNCE and MANUAL: led SHALL always equal one-hot(position).
REQ-019 BLINK: led SHALL toggle between all-ones and all-zeros on each tick.
- First tick after entering BLINK yields all-ones.
- position is held.
REQ-020 MANUAL: prescaler SHALL be held at 0.
- Each STEP write advances position one CHASE step per CTRL.dir.
- step_tick pulses in the write cycle.
- STEP writes in any other mode or in IDLE are ignored.
REQ-021 In IDLE:
- led SHALL be all-zeros from the cycle after entry.
- Prescaler cleared; position and bounce_dir held; step_tick=0.
REQ-022 Any CTRL write SHALL:
- clear the prescaler;
- load bounce_dir from CTRL.dir;
- retain position;
- drive led to one-hot(position) if the new state is RUN and the mode is not BLINK, or to all-zeros if the mode is BLINK.
REQ-023 A CTRL write coinciding with a prescaler terminal count SHALL suppress that tick (no step_tick, no advance).
REQ-024 A PERIOD write SHALL take effect next cycle.
- If the current count >= the new PERIOD, count SHALL restart at 0 without generating a tick.
REQ-025 A write with cfg_addr outside the defined writable registers SHALL have no effect.

Reset
REQ-026 On rst=1 at a clock edge, the following SHALL be loaded:
- enable=0, mode=CHASE, dir=0, bounce_dir=up;
- PERIOD=all-ones, count=0, position=0;
- led=all-zeros, step_tick=0.
REQ-027 rst SHALL take priority over a simultaneous cfg_we.
REQ-028 Reset mid-sequence SHALL return the block to IDLE within one cycle, with no residual step_tick.

Verification
REQ-029 CHASE run: PERIOD=3, CTRL=0x1.
- step_tick every 4th cycle.
- led sequence 0000001->0000010->...->1000000->0000001.
- 7 ticks returns to position 0.
REQ-030 BOUNCE: PERIOD=0, CTRL=0x3.
- led positions 0,1,2,3,4,5,6,5,4,...,0,1.
- STATUS bit1 flips at positions 6 and 0.
REQ-031 MANUAL with dir=1 (CTRL=0xF, position 0).
- Three STEP writes give positions 6,5,4, each with a step_tick pulse.
- No ticks occur between writes.
REQ-032 Collision: CTRL write lands on the terminal count.
- No step_tick, position unchanged.
- Next tick occurs PERIOD+1 cycles later.
- PERIOD shrink from 100 to 5 at count 50: count restarts at 0, next tick 6 cycles later.
REQ-033 BLINK and disable:
- CTRL=0x5, PERIOD=1: led toggles 1111111/0000000 every 2 cycles.
- CTRL=0x0 write: led=0 next cycle, position unchanged.
- rst mid-run: all REQ-026 values observed after one edge.
